uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 8, number of byte entries in the transmit FIFO; power of two, at least 2.
REQ-003 Parameter STOP_BITS, default 1, number of stop bits per frame; legal values 1 or 2.
REQ-004 clk  input  1  system clock, 100 MHz; single clock domain.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 i_data  input  8  byte to transmit.
REQ-007 i_valid  input  1  i_data is valid this cycle.
REQ-008 o_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 o_tx  output  1  serial line; idle high.
REQ-010 o_busy  output  1  frame in progress or FIFO non-empty.
REQ-011 o_fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes currently queued, excluding the byte being shifted.

Function
REQ-012 Accept: a byte SHALL be written on a rising edge where i_valid and o_ready are both high; i_data is ignored otherwise.
REQ-013 o_ready SHALL equal (o_fifo_count != FIFO_DEPTH); a write attempt while full is dropped and leaves FIFO contents unchanged.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP.
REQ-015 IDLE: o_tx=1; if the FIFO is non-empty, pop the head byte into the shift register and go to START on the same edge.
REQ-016 START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-017 DATA: o_tx=shift[0], LSB first; each bit held CLKS_PER_BIT cycles; after bit 7 go to STOP.
REQ-018 STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles; at the end, pop and go to START if the FIFO is non-empty (no idle gap), else go to IDLE.
REQ-019 o_tx SHALL be driven from a flip-flop (glitch-free).
REQ-020 Latency: with the FSM in IDLE and the FIFO empty, if a byte is accepted at edge E, o_tx SHALL fall at edge E+2.
REQ-021 The baud counter SHALL run 0..CLKS_PER_BIT-1, wrap to 0 at every bit boundary, and reset on every state entry.
REQ-022 A push and a pop on the same edge SHALL leave o_fifo_count unchanged; the FIFO pointers wrap modulo FIFO_DEPTH.
REQ-023 Frame length SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles; a queued byte stream is sent back-to-back at that period.
REQ-024 o_busy SHALL be 0 only when in IDLE with an empty FIFO.

Reset
REQ-025 Asserting rst_n low SHALL immediately force: state IDLE, o_tx=1, o_busy=0, o_fifo_count=0, o_ready=1, baud counter 0, bit index 0, FIFO pointers 0.
REQ-026 Reset during a frame SHALL abort it; the line returns high, and queued bytes are discarded.
REQ-027 After rst_n deasserts, the first write SHALL be accepted on the first rising edge.

Structure
REQ-028 Shared package uart_pkg SHALL hold the default CLKS_PER_BIT (868), the default FIFO_DEPTH, and the tx state enumeration.
REQ-029 The FIFO SHALL be a separate sub-module, sync_fifo (parameterised width and depth, full/empty/count), instantiated once.

Verification
REQ-030 Single byte 0x41 after reset -> o_tx low at E+2, bit pattern 0,1,0,0,0,0,0,1,0,1, each bit exactly 868 cycles; o_busy falls after the stop bit.
REQ-031 Burst 0x00, 0x26, 0xFF pushed on consecutive cycles -> three frames back-to-back with no idle cycles between them; the decoded bytes match in order.
REQ-032 Push 9 bytes with FIFO_DEPTH=8 while the first byte is shifting -> o_ready low when the count reaches 8; the extra write is dropped; 9 bytes total are transmitted, with no duplicates.
REQ-033 Simultaneous push and pop at a frame boundary with count 3 -> count stays 3; no byte is lost.
REQ-034 Assert rst_n mid-DATA of byte 0xA5 -> o_tx=1 and count 0 immediately; after release, pushing 0x5A yields a clean frame.
REQ-035 STOP_BITS=2, byte 0xE0 -> frame of 11*868 cycles; the line stays high for 1736 cycles after bit 7.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and transmitter state encoding for the buffered UART
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int FIFO_DEPTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with full/empty flags and occupancy count
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1/8N2 UART transmitter fed by a byte FIFO, back-to-back frames
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int STOP_BITS = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        i_data,
  input  logic                              i_valid,
  output logic                              o_ready,
  output logic                              o_tx,
  output logic                              o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  tx_state_t state, state_nx;
  logic [BW-1:0] cnt, cnt_nx;
  logic [2:0] idx, idx_nx;
  logic [7:0] shift, shift_nx, head;
  logic full, empty, pop, bit_end;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(i_valid),
    .wr_data(i_data),
    .rd_en(pop),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(o_fifo_count)
  );
  assign o_ready = !full;
  assign o_busy = state != IDLE || !empty;
  assign bit_end = cnt == LAST;
  // idx counts data bits in DATA and stop bits in STOP; it is 0 on entry to both
  always_comb begin
    state_nx = state;
    cnt_nx = bit_end ? '0 : cnt + BW'(1);
    idx_nx = idx;
    shift_nx = shift;
    pop = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        pop = !empty;
        state_nx = empty ? IDLE : START;
      end
      START: state_nx = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        shift_nx = shift >> 1;
        idx_nx = idx + 3'd1;
        state_nx = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        idx_nx = idx == LAST_STOP ? 3'd0 : idx + 3'd1;
        pop = idx == LAST_STOP && !empty;
        state_nx = idx != LAST_STOP ? STOP : empty ? IDLE : START;
      end
      default: state_nx = IDLE;
    endcase
    if (pop) shift_nx = head;
  end
  // o_tx follows the registered state, which puts the start bit two edges after the write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      o_tx <= 1'b1;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      idx <= idx_nx;
      shift <= shift_nx;
      o_tx <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed and random byte streams checked against a frame-level line model
module tb_uart_tx_buffered;
  localparam int C = 16;
  localparam int D = 8;
  localparam int F = 10 * C;
  localparam int C2 = 868;
  localparam int F2 = 11 * C2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] data = '0, data2 = '0;
  logic valid = 1'b0, valid2 = 1'b0;
  logic ready, tx, busy, ready2, tx2, busy2;
  logic [3:0] cnt, cnt2;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int n_done = 0, n_exp = 0, gap_acc = 0, last_end = 0;
  bit track = 1'b0;
  logic [7:0] mb;
  bit ab;

  uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_tx(tx), .o_busy(busy), .o_fifo_count(cnt)
  );
  uart_tx_buffered #(.STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_data(data2), .i_valid(valid2),
    .o_ready(ready2), .o_tx(tx2), .o_busy(busy2), .o_fifo_count(cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // line level i cycles after the start bit begins: start, 8 data bits LSB first, then high
  function automatic logic level(input logic [7:0] b, input int i, input int c);
    int k = i / c;
    return k == 0 ? 1'b0 : k <= 8 ? b[k-1] : 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    data = b;
    valid = 1'b1;
    if (acc) begin
      exp_q.push_back(b);
      n_exp++;
    end
    tick();
    valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((n_done != n_exp || busy) && n < 40 * F) begin
      tick();
      n++;
    end
    check(tag, n_done == n_exp && !busy, 1);
  endtask

  // line monitor: every frame must match the next expected byte cycle for cycle
  initial forever begin
    tick();
    if (rst_n && tx === 1'b0) begin
      check("frame_expected", exp_q.size() != 0, 1);
      mb = exp_q.size() != 0 ? exp_q.pop_front() : 8'h00;
      if (track) gap_acc += cyc - last_end - 1;
      ab = 1'b0;
      for (int i = 0; i < F; i++) begin
        if (!rst_n) begin
          ab = 1'b1;
          break;
        end
        check("frame_bit", tx, level(mb, i, C));
        if (i < F - 1) tick();
      end
      if (!ab) begin
        n_done++;
        last_end = cyc;
        track = 1'b1;
      end
    end
  end

  initial begin
    logic [7:0] b;
    bit acc;
    int mc;
    #1 rst_n = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_cnt", cnt, 0);
    check("rst_ready", ready, 1);
    check("rst_tx2", tx2, 1);
    @(negedge clk) rst_n = 1'b1;
    tick();
    push(8'h41, 1);
    check("lat_e0", tx, 1);
    check("single_cnt", cnt, 1);
    tick();
    check("lat_e1", tx, 1);
    check("busy_e1", busy, 1);
    tick();
    check("lat_e2", tx, 0);
    repeat (F - 2) tick();
    check("busy_stop", busy, 1);
    tick();
    check("busy_fall", busy, 0);
    drain("drain_single");

    track = 1'b0;
    gap_acc = 0;
    push(8'h00, 1);
    check("burst_cnt0", cnt, 1);
    push(8'h26, 1);
    check("burst_cnt1", cnt, 1);
    push(8'hFF, 1);
    check("burst_cnt2", cnt, 2);
    drain("drain_burst");
    check("burst_gap", gap_acc, 0);

    mc = 0;
    push(8'($urandom), 1);
    tick();
    check("ovf_cnt_start", cnt, 0);
    for (int i = 0; i < D + 1; i++) begin
      b = 8'($urandom);
      acc = mc < D;
      check("ovf_ready", ready, mc != D);
      push(b, acc);
      if (acc) mc++;
      check("ovf_cnt", cnt, mc);
    end
    check("ovf_ready_full", ready, 0);
    drain("drain_ovf");

    track = 1'b0;
    gap_acc = 0;
    push(8'($urandom), 1);
    push(8'($urandom), 1);
    push(8'($urandom), 1);
    push(8'($urandom), 1);
    check("bnd_cnt3", cnt, 3);
    repeat (F - 3) tick();
    check("bnd_cnt_before", cnt, 3);
    push(8'($urandom), 1);
    check("bnd_cnt_same", cnt, 3);
    drain("drain_bnd");
    check("bnd_gap", gap_acc, 0);

    for (int i = 0; i < 5; i++) begin
      push(8'($urandom), 1);
      repeat ($urandom_range(0, 2 * F)) tick();
    end
    drain("drain_rand");

    push(8'hA5, 1);
    repeat (2 + 3 * C + C / 2) tick();
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_cnt", cnt, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", ready, 1);
    exp_q.delete();
    n_exp = n_done;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    push(8'h5A, 1);
    check("first_edge_accept", cnt, 1);
    drain("drain_after_rst");

    data2 = 8'hE0;
    valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    tick();
    check("s2_lat1", tx2, 1);
    tick();
    for (int i = 0; i < F2; i++) begin
      check("s2_bit", tx2, level(8'hE0, i, C2));
      if (i == F2 - 2) check("s2_busy_stop", busy2, 1);
      tick();
    end
    check("s2_idle_tx", tx2, 1);
    check("s2_busy_fall", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
